// File: rtl/rv_ahb_master.sv
// AHB-Lite master: in-order request FIFO feeding one address phase and one data phase per cycle.
// Optional macro RV_AHB_MASTER_ERR_EN enables two-cycle ERROR handling with retry of the cancelled address phase.
module rv_ahb_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [2:0]        req_size,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_vld,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        HTRANS,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  localparam int unsigned    PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] S_NONE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_ERR2 = 2'd2;

  // Request FIFO storage
  logic [ADDR_W-1:0] r_mem_addr  [DEPTH];
  logic              r_mem_write [DEPTH];
  logic [2:0]        r_mem_size  [DEPTH];
  logic [DATA_W-1:0] r_mem_wdata [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_dp_write;
  logic [DATA_W-1:0] r_hwdata;
  logic [ADDR_W-1:0] r_last_addr;
  logic              r_last_write;
  logic [2:0]        r_last_size;
  logic              r_rsp_vld;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_cancel;
  logic w_ap_active;
  logic w_ap_done;
  logic w_dp_done;
  logic w_dp_err;
  logic w_err_start;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_push  = req_vld && !w_full;

`ifdef RV_AHB_MASTER_ERR_EN
  // Second ERROR cycle: address phase is withdrawn and the head stays queued for retry
  assign w_cancel    = (r_state == S_ERR2);
  assign w_err_start = HRESP && !HREADY;
  assign w_dp_err    = (r_state == S_ERR2) || HRESP;
`else
  logic w_unused_hresp;
  assign w_unused_hresp = HRESP;
  assign w_cancel       = 1'b0;
  assign w_err_start    = 1'b0;
  assign w_dp_err       = 1'b0;
`endif

  assign w_ap_active = !w_empty && !w_cancel;
  assign w_ap_done   = w_ap_active && HREADY;
  assign w_dp_done   = (r_state != S_NONE) && HREADY;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr]  <= req_addr;
      r_mem_write[r_wr_ptr] <= req_write;
      r_mem_size[r_wr_ptr]  <= req_size;
      r_mem_wdata[r_wr_ptr] <= req_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_ap_done) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_ap_done})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_NONE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_NONE: begin
        if (w_ap_done) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (HREADY) begin
          w_state_nxt = w_ap_done ? S_DATA : S_NONE;
        end else if (w_err_start) begin
          w_state_nxt = S_ERR2;
        end
      end
      S_ERR2: begin
        if (HREADY) begin
          w_state_nxt = S_NONE;
        end
      end
      default: w_state_nxt = S_NONE;
    endcase
  end

  // Data-phase register and last-driven address-phase controls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dp_write   <= 1'b0;
      r_hwdata     <= '0;
      r_last_addr  <= '0;
      r_last_write <= 1'b0;
      r_last_size  <= '0;
    end else if (w_ap_done) begin
      r_dp_write   <= r_mem_write[r_rd_ptr];
      r_last_addr  <= r_mem_addr[r_rd_ptr];
      r_last_write <= r_mem_write[r_rd_ptr];
      r_last_size  <= r_mem_size[r_rd_ptr];
      if (r_mem_write[r_rd_ptr]) begin
        r_hwdata <= r_mem_wdata[r_rd_ptr];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_vld   <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_vld   <= w_dp_done;
      r_rsp_rdata <= (w_dp_done && !r_dp_write && !w_dp_err) ? HRDATA : '0;
      r_rsp_err   <= w_dp_done && w_dp_err;
    end
  end

  // Address phase shows the FIFO head; idle bus keeps the last issued controls
  always_comb begin
    HTRANS = w_ap_active ? HTRANS_NONSEQ : HTRANS_IDLE;
    HADDR  = r_last_addr;
    HWRITE = r_last_write;
    HSIZE  = r_last_size;
    if (!w_empty) begin
      HADDR  = r_mem_addr[r_rd_ptr];
      HWRITE = r_mem_write[r_rd_ptr];
      HSIZE  = r_mem_size[r_rd_ptr];
    end
  end

  assign HWDATA    = r_hwdata;
  assign req_rdy   = !w_full;
  assign rsp_vld   = r_rsp_vld;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
